// File: rtl/delay_channel_scheduler.sv
// Multi-channel microsecond countdown scheduler behind one custom-instruction id.
// One shared prescaler ticks every channel; a blocking WAIT parks the CI until its channel expires.

module delay_channel (
   input  logic        clock,
   input  logic        reset,
   input  logic        tick,
   input  logic        arm,
   input  logic        cancel,
   input  logic        clearFlag,
   input  logic        suppressFlag,
   input  logic [31:0] armValue,
   output logic [31:0] count,
   output logic        running,
   output logic        flag,
   output logic        expiring
);

   assign expiring = tick && running && (count == 32'd1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count   <= '0;
         running <= 1'b0;
         flag    <= 1'b0;
      end else if (arm) begin
         count   <= armValue;
         running <= (armValue != 32'd0);
         flag    <= (armValue == 32'd0);
      end else if (cancel) begin
         count   <= '0;
         running <= 1'b0;
         flag    <= 1'b0;
      end else begin
         if (expiring) begin
            count   <= '0;
            running <= 1'b0;
         end else if (tick && running) begin
            count <= count - 32'd1;
         end
         // a fresh expiry beats an ACK; a blocked WAIT swallows it instead
         if (expiring && !suppressFlag) flag <= 1'b1;
         else if (clearFlag)            flag <= 1'b0;
      end
   end

endmodule

module delay_channel_scheduler #(
   parameter int         clockFrequencyInHz  = 50000000,
   parameter logic [7:0] customInstructionId = 8'd0,
   parameter int         nrOfChannels        = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ciStart,
   input  logic                    ciCke,
   input  logic [7:0]              ciN,
   input  logic [31:0]             ciValueA,
   input  logic [31:0]             ciValueB,
   output logic                    ciDone,
   output logic [31:0]             ciResult,
   output logic [nrOfChannels-1:0] expiredFlags,
   output logic                    irq
);

   localparam int                   reloadValue  = clockFrequencyInHz / 1000000 - 1;
   localparam int                   prescWidth   = $clog2(reloadValue + 1);
   localparam logic [prescWidth-1:0] reloadCount = prescWidth'(reloadValue);
   localparam logic [3:0]           channelLimit = 4'(nrOfChannels);

   typedef enum logic {stIdle, stWait} stateT;

   stateT                         state;
   logic [prescWidth-1:0]         prescaler;
   logic                          tick;
   logic [nrOfChannels-1:0][31:0] count;
   logic [nrOfChannels-1:0]       running, expiring, chHit, waitMask;
   logic [nrOfChannels-1:0]       armMask, cancelMask, clearMask, suppressMask;
   logic [2:0]                    opcode, chSel;
   logic                          chValid, accept;
   logic                          armCmd, waitCmd, cancelCmd, ackCmd;
   logic                          waitDefer, waitCatch, waitEnd;
   logic [31:0]                   selCount, resultNext;
   logic                          selRunning, selFlag, selExpiring;
   logic                          unusedOperandBits;

   assign opcode            = ciValueB[2:0];
   assign chSel             = ciValueB[5:3];
   assign unusedOperandBits = ^ciValueB[31:6];
   assign chValid           = {1'b0, chSel} < channelLimit;
   assign accept            = ciStart && ciCke && (ciN == customInstructionId) && (state == stIdle);
   assign tick              = (prescaler == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)    prescaler <= reloadCount;
      else if (tick) prescaler <= reloadCount;
      else           prescaler <= prescaler - 1'b1;
   end

   always_comb begin
      selCount    = '0;
      selRunning  = 1'b0;
      selFlag     = 1'b0;
      selExpiring = 1'b0;
      for (int i = 0; i < nrOfChannels; i++) begin
         if (chHit[i]) begin
            selCount    = count[i];
            selRunning  = running[i];
            selFlag     = expiredFlags[i];
            selExpiring = expiring[i];
         end
      end
   end

   assign armCmd    = accept && chValid && (opcode == 3'd0);
   assign waitCmd   = accept && chValid && (opcode == 3'd1);
   assign cancelCmd = accept && chValid && (opcode == 3'd3);
   assign ackCmd    = accept && chValid && (opcode == 3'd4);
   // a WAIT landing on the expiry edge completes at once rather than parking forever
   assign waitCatch = waitCmd && selRunning && !selFlag && selExpiring;
   assign waitDefer = waitCmd && selRunning && !selFlag && !selExpiring;
   assign waitEnd   = (state == stWait) && |(expiring & waitMask);

   assign armMask      = armCmd    ? chHit : '0;
   assign cancelMask   = cancelCmd ? chHit : '0;
   assign clearMask    = (ackCmd ? ciValueA[nrOfChannels-1:0] : '0) | ((waitCmd && selFlag) ? chHit : '0);
   assign suppressMask = (waitEnd ? waitMask : '0) | (waitCatch ? chHit : '0);

   genvar g;
   generate
      for (g = 0; g < nrOfChannels; g++) begin : genChannel
         assign chHit[g] = chValid && (chSel == 3'(g));
         delay_channel uChannel (
            .clock       (clock),
            .reset       (reset),
            .tick        (tick),
            .arm         (armMask[g]),
            .cancel      (cancelMask[g]),
            .clearFlag   (clearMask[g]),
            .suppressFlag(suppressMask[g]),
            .armValue    (ciValueA),
            .count       (count[g]),
            .running     (running[g]),
            .flag        (expiredFlags[g]),
            .expiring    (expiring[g])
         );
      end
   endgenerate

   always_comb begin
      resultNext = '0;
      case (opcode)
         3'd1:    resultNext = {31'd0, selFlag || waitCatch};
         3'd2:    resultNext = selCount;
         3'd3:    resultNext = selCount;
         3'd4:    resultNext = 32'(expiredFlags);
         default: resultNext = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= stIdle;
         waitMask <= '0;
         ciDone   <= 1'b0;
         ciResult <= '0;
         irq      <= 1'b0;
      end else begin
         irq      <= |expiredFlags;
         ciDone   <= 1'b0;
         ciResult <= '0;
         case (state)
            stIdle: begin
               if (accept) begin
                  if (waitDefer) begin
                     state    <= stWait;
                     waitMask <= chHit;
                  end else begin
                     ciDone   <= 1'b1;
                     ciResult <= chValid ? resultNext : 32'd0;
                  end
               end
            end
            stWait: begin
               if (waitEnd) begin
                  state    <= stIdle;
                  waitMask <= '0;
                  ciDone   <= 1'b1;
                  ciResult <= 32'd1;
               end
            end
            default: state <= stIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_channel_scheduler.sv
// Randomized + directed bench for delay_channel_scheduler with a cycle-level reference model and result scoreboard.

module tb_delay_channel_scheduler;

   localparam int         FREQ = 4000000;
   localparam int         NCH  = 4;
   localparam logic [7:0] ID   = 8'h2A;
   localparam int         TPU  = FREQ / 1000000;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           ciStart = 1'b0, ciCke = 1'b0;
   logic [7:0]     ciN = 8'd0;
   logic [31:0]    ciValueA = '0, ciValueB = '0;
   logic           ciDone;
   logic [31:0]    ciResult;
   logic [NCH-1:0] expiredFlags;
   logic           irq;

   delay_channel_scheduler #(
      .clockFrequencyInHz (FREQ),
      .customInstructionId(ID),
      .nrOfChannels       (NCH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ciStart     (ciStart),
      .ciCke       (ciCke),
      .ciN         (ciN),
      .ciValueA    (ciValueA),
      .ciValueB    (ciValueB),
      .ciDone      (ciDone),
      .ciResult    (ciResult),
      .expiredFlags(expiredFlags),
      .irq         (irq)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned edgeCnt;
   int unsigned mCnt[NCH];
   bit          mRun[NCH];
   bit          mFlag[NCH];
   bit          mIrq;
   bit          mWaiting;
   int          mWaitCh;
   int unsigned expQ[$];

   function automatic int unsigned packFlags();
      int unsigned v = 0;
      for (int i = 0; i < NCH; i++) if (mFlag[i]) v |= (1 << i);
      return v;
   endfunction

   always @(posedge clock or negedge reset) begin
      bit          isTick, accepted, chOk;
      bit          expNow[NCH], consumed[NCH], setNow[NCH];
      int          op, ch;
      int unsigned flagsVal;
      if (!reset) begin
         edgeCnt  = 0;
         mIrq     = 0;
         mWaiting = 0;
         mWaitCh  = 0;
         for (int i = 0; i < NCH; i++) begin
            mCnt[i] = 0; mRun[i] = 0; mFlag[i] = 0;
         end
         expQ.delete();
      end else begin
         isTick   = (edgeCnt % TPU) == TPU - 1;
         edgeCnt++;
         flagsVal = packFlags();
         mIrq     = (flagsVal != 0);
         accepted = ciStart && ciCke && (ciN == ID) && !mWaiting;
         op       = int'(ciValueB[2:0]);
         ch       = int'(ciValueB[5:3]);
         chOk     = ch < NCH;
         for (int i = 0; i < NCH; i++) begin
            expNow[i]   = isTick && mRun[i] && mCnt[i] == 1;
            consumed[i] = 0;
            setNow[i]   = 0;
         end
         if (mWaiting && expNow[mWaitCh]) begin
            expQ.push_back(1);
            consumed[mWaitCh] = 1;
            mWaiting = 0;
         end
         if (accepted) begin
            if (!chOk) expQ.push_back(0);
            else case (op)
               1: begin
                  if (mFlag[ch])           expQ.push_back(1);
                  else if (!mRun[ch])      expQ.push_back(0);
                  else if (expNow[ch]) begin expQ.push_back(1); consumed[ch] = 1; end
                  else begin mWaiting = 1; mWaitCh = ch; end
               end
               2, 3:    expQ.push_back(mCnt[ch]);
               4:       expQ.push_back(flagsVal);
               default: expQ.push_back(0);
            endcase
         end
         for (int i = 0; i < NCH; i++) begin
            if (expNow[i]) begin
               mCnt[i] = 0; mRun[i] = 0;
               if (!consumed[i]) begin mFlag[i] = 1; setNow[i] = 1; end
            end else if (isTick && mRun[i]) mCnt[i]--;
         end
         if (accepted && chOk) begin
            case (op)
               0: begin
                  mCnt[ch] = ciValueA; mRun[ch] = (ciValueA != 0); mFlag[ch] = (ciValueA == 0);
               end
               1: if (!setNow[ch]) mFlag[ch] = 0;
               3: begin mCnt[ch] = 0; mRun[ch] = 0; mFlag[ch] = 0; end
               4: for (int i = 0; i < NCH; i++) if (ciValueA[i] && !setNow[i]) mFlag[i] = 0;
               default: ;
            endcase
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      if (reset) begin
         if (ciDone) begin
            tests++;
            if (expQ.size() == 0) begin
               fails++;
               $display("FAIL unexpectedDone: got result 0x%0h with nothing expected at %0t", ciResult, $time);
            end else check("scoreResult", ciResult, expQ.pop_front());
         end else check("idleResult", ciResult, 32'd0);
         check("flags", 32'(expiredFlags), packFlags());
         check("irq", {31'd0, irq}, {31'd0, mIrq});
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic issue(input int op, input int ch, input logic [31:0] a, input logic [7:0] n,
                        output logic done, output logic [31:0] res);
      ciStart  = 1'b1;
      ciCke    = 1'b1;
      ciN      = n;
      ciValueA = a;
      ciValueB = {26'd0, 3'(ch), 3'(op)};
      @(negedge clock);
      ciStart  = 1'b0;
      done     = ciDone;
      res      = ciResult;
   endtask

   task automatic waitDone(input string name, input int budget, output logic [31:0] res);
      res = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (ciDone) begin
            res = ciResult;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL %s: no ciDone within %0d cycles", name, budget);
   endtask

   task automatic alignToTick();
      for (int i = 0; i < 2 * TPU && (edgeCnt % TPU) != TPU - 1; i++) @(negedge clock);
   endtask

   logic        dn;
   logic [31:0] rs;
   int unsigned armEdge, t3, seen, snap;

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      check("rstFlags", 32'(expiredFlags), 32'd0);
      check("rstIrq", {31'd0, irq}, 32'd0);
      check("rstDone", {31'd0, ciDone}, 32'd0);
      check("rstResult", ciResult, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // ARM ch0=3 then block on it; completion on the 3rd tick edge after ARM
      armEdge = edgeCnt;
      issue(0, 0, 3, ID, dn, rs);
      check("armDone", {31'd0, dn}, 32'd1);
      issue(1, 0, 0, ID, dn, rs);
      check("waitPending", {31'd0, dn}, 32'd0);
      waitDone("wait0", 40, rs);
      check("wait0Result", rs, 32'd1);
      t3 = armEdge + 1 + ((TPU - 1) - ((armEdge + 1) % TPU)) + 2 * TPU;
      check("wait0Edge", edgeCnt - 1, t3);
      check("wait0Flag", {31'd0, expiredFlags[0]}, 32'd0);
      check("wait0Irq", {31'd0, irq}, 32'd0);

      // ch1=10, ch2=2, read ch1 after 4 ticks
      issue(0, 1, 10, ID, dn, rs);
      seen = 0;
      issue(0, 2, 2, ID, dn, rs);
      if (((edgeCnt - 1) % TPU) == TPU - 1) seen++;
      for (int i = 0; i < 40 && seen < 4; i++) begin
         @(negedge clock);
         if (((edgeCnt - 1) % TPU) == TPU - 1) seen++;
      end
      check("flag2Set", {31'd0, expiredFlags[2]}, 32'd1);
      check("irqSet", {31'd0, irq}, 32'd1);
      issue(2, 1, 0, ID, dn, rs);
      check("read1", rs, 32'd6);
      issue(4, 0, 32'h4, ID, dn, rs);
      check("ackResult", rs, 32'h4);
      check("ackFlags", 32'(expiredFlags), 32'd0);
      check("ackIrqLag", {31'd0, irq}, 32'd1);
      @(negedge clock);
      check("ackIrqDrop", {31'd0, irq}, 32'd0);

      // zero-length ARM and WAIT on flagged/idle channels
      issue(0, 3, 0, ID, dn, rs);
      check("arm0Flag", {31'd0, expiredFlags[3]}, 32'd1);
      issue(1, 3, 0, ID, dn, rs);
      check("wait3Done", {31'd0, dn}, 32'd1);
      check("wait3Result", rs, 32'd1);
      check("wait3Flag", {31'd0, expiredFlags[3]}, 32'd0);
      issue(1, 0, 0, ID, dn, rs);
      check("waitIdleResult", rs, 32'd0);

      // CANCEL in the expiry cycle
      issue(0, 1, 1, ID, dn, rs);
      alignToTick();
      issue(3, 1, 0, ID, dn, rs);
      check("cancelExpResult", rs, 32'd1);
      @(negedge clock);
      check("cancelExpFlag", {31'd0, expiredFlags[1]}, 32'd0);

      // ARM in the tick cycle wins over the decrement
      issue(0, 2, 9, ID, dn, rs);
      alignToTick();
      issue(0, 2, 5, ID, dn, rs);
      issue(2, 2, 0, ID, dn, rs);
      check("armTickRead", rs, 32'd5);

      // out-of-range channel and foreign CI id
      snap = 32'(expiredFlags);
      issue(0, 6, 7, ID, dn, rs);
      check("ch6Done", {31'd0, dn}, 32'd1);
      check("ch6Result", rs, 32'd0);
      check("ch6Flags", 32'(expiredFlags), snap);
      issue(2, 0, 0, ID ^ 8'h01, dn, rs);
      check("foreignId", {31'd0, dn}, 32'd0);

      // reset while blocked
      issue(0, 0, 100, ID, dn, rs);
      issue(1, 0, 0, ID, dn, rs);
      check("longWaitPending", {31'd0, dn}, 32'd0);
      repeat (20) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rstDoneLow", {31'd0, ciDone}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      issue(2, 0, 0, ID, dn, rs);
      check("postRstDone", {31'd0, dn}, 32'd1);
      check("postRstRead", rs, 32'd0);

      // randomized traffic, checked by the scoreboard
      for (int k = 0; k < 3000; k++) begin
         int r;
         r        = int'($urandom_range(0, 9));
         ciStart  = ($urandom_range(0, 3) == 0);
         ciCke    = ($urandom_range(0, 7) != 0);
         ciN      = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ID;
         ciValueB = {26'd0,
                     ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, NCH - 1)),
                     (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 6) ? 3'd2 : (r < 7) ? 3'd3 :
                     (r < 9) ? 3'd4 : 3'($urandom_range(5, 7))};
         ciValueA = (ciValueB[2:0] == 3'd0) ? 32'($urandom_range(0, 11)) : $urandom;
         @(negedge clock);
      end
      ciStart = 1'b0;
      repeat (200) @(negedge clock);
      check("drainQueue", expQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
